dsp_mac_inverter: RTL and testbench

- Sequential inverse of the team's multiply-add pipeline P = A*(D+B) + C.
- Given a result P, the addend C and the multiplier A, it recovers the pre-adder sum S = (P - C) / A and the remainder.
- Used on the verification/readback side of the DSP datapath to check results and to back-solve pre-adder operands.
- Valid/ready handshake on both sides; restoring division producing one quotient bit per cycle.

---
 rtl/dsp_inv_pkg.sv | 16 +
 rtl/dsp_inv_seq_restoring_div.sv | 70 +++++++
 rtl/dsp_mac_inverter.sv | 141 ++++++++++++++
 tb/tb_dsp_mac_inverter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_inv_pkg.sv
// Shared types and default widths for the multiply-add inverter.
package dsp_inv_pkg;

    localparam int AW_DEF  = 18;
    localparam int PW_DEF  = 48;
    localparam int SW_DEF  = AW_DEF + 1;
    localparam int CNT_W   = $clog2(PW_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_inv_seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// i_start loads the dividend and divisor and clears the partial remainder.
// o_last is high during the final iteration; o_quot/o_rem then show the
// values that this final edge completes, so the caller can latch them.
module seq_restoring_div
    import dsp_inv_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [PW-1:0] i_dividend,
    input  logic [AW-1:0] i_divisor,
    output logic          o_last,
    output logic [PW-1:0] o_quot,
    output logic [AW-1:0] o_rem
);

    localparam int CW = $clog2(PW);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_div;
    logic [AW-1:0] r_rem;      // partial remainder, always < divisor
    logic [PW-1:0] r_shift;    // dividend bits shift out the top, quotient bits in the bottom

    logic [AW:0]   w_trial;
    logic          w_ge;
    logic [AW-1:0] w_rem_next;
    logic [PW-1:0] w_quot_next;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        w_trial     = {r_rem, r_shift[PW-1]};
        w_ge        = (w_trial >= {1'b0, r_div});
        w_rem_next  = AW'(w_ge ? (w_trial - {1'b0, r_div}) : w_trial);
        w_quot_next = {r_shift[PW-2:0], w_ge};
    end

    assign o_last = r_busy && (r_cnt == CW'(PW - 1));
    assign o_quot = w_quot_next;
    assign o_rem  = w_rem_next;

    // Iteration register: load on start, one restoring step per clock while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_shift <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= i_divisor;
            r_rem   <= '0;
            r_shift <= i_dividend;
        end else if (r_busy) begin
            r_rem   <= w_rem_next;
            r_shift <= w_quot_next;
            r_cnt   <= r_cnt + 1'b1;
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dsp_mac_inverter.sv
// Back-solves S = (P - C) / A for the multiply-add P = A*(D+B) + C.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds data stable while valid && !ready, and
// out_valid stays high with stable results until out_ready accepts them.
module dsp_mac_inverter
    import dsp_inv_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] p_in,
    input  logic [PW-1:0] c_in,
    input  logic [AW-1:0] a_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] sum_out,
    output logic [AW-1:0] rem_out,
    output logic          err_div0,
    output logic          err_under,
    output logic          err_ovf,
    output logic [1:0]    dbg_state
);

    state_t        r_state;
    state_t        w_state_next;

    logic [PW-1:0] r_p;
    logic [PW-1:0] r_c;
    logic [AW-1:0] r_a;
    logic [SW-1:0] r_sum;
    logic [AW-1:0] r_rem;
    logic          r_div0;
    logic          r_under;
    logic          r_ovf;

    logic [PW:0]   w_diff;
    logic          w_under;
    logic          w_div0;
    logic          w_err;
    logic          w_start;
    logic          w_last;
    logic [PW-1:0] w_quot;
    logic [AW-1:0] w_rem;
    logic          w_ovf;
    logic [SW-1:0] w_sum_sat;

    // Borrow-detecting subtract, error checks and quotient saturation.
    always_comb begin
        w_diff    = {1'b0, r_p} - {1'b0, r_c};
        w_under   = w_diff[PW];
        w_div0    = (r_a == '0);
        w_err     = w_under || w_div0;
        w_start   = (r_state == SUB) && !w_err;
        w_ovf     = |w_quot[PW-1:SW];
        w_sum_sat = w_ovf ? {SW{1'b1}} : w_quot[SW-1:0];
    end

    seq_restoring_div #(
        .PW (PW),
        .AW (AW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (w_diff[PW-1:0]),
        .i_divisor  (r_a),
        .o_last     (w_last),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Next-state logic for the accept / subtract / divide / hold sequence.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid)  w_state_next = SUB;
            SUB:  w_state_next = w_err ? DONE : DIV;
            DIV:  if (w_last)    w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture and result/flag registers, updated only on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_c     <= '0;
            r_a     <= '0;
            r_sum   <= '0;
            r_rem   <= '0;
            r_div0  <= 1'b0;
            r_under <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_p <= p_in;
                r_c <= c_in;
                r_a <= a_in;
            end
            if (r_state == SUB && w_err) begin
                r_sum   <= '0;
                r_rem   <= '0;
                r_div0  <= w_div0;
                r_under <= w_under;
                r_ovf   <= 1'b0;
            end
            if (r_state == DIV && w_last) begin
                r_sum   <= w_sum_sat;
                r_rem   <= w_rem;
                r_div0  <= 1'b0;
                r_under <= 1'b0;
                r_ovf   <= w_ovf;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum_out   = r_sum;
    assign rem_out   = r_rem;
    assign err_div0  = r_div0;
    assign err_under = r_under;
    assign err_ovf   = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dsp_mac_inverter.sv
// Directed bench for dsp_mac_inverter with a queue-based result scoreboard.
module tb_dsp_mac_inverter;

    localparam int AW = 18;
    localparam int PW = 48;
    localparam int SW = 19;
    localparam int EW = SW + AW + 3;   // {sum, rem, div0, under, ovf}
    localparam int NORM_LAT = PW + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] p_in;
    logic [PW-1:0] c_in;
    logic [AW-1:0] a_in;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum_out;
    logic [AW-1:0] rem_out;
    logic          err_div0;
    logic          err_under;
    logic          err_ovf;
    logic [1:0]    dbg_state;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    dsp_mac_inverter #(.AW(AW), .PW(PW), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .c_in      (c_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .rem_out   (rem_out),
        .err_div0  (err_div0),
        .err_under (err_under),
        .err_ovf   (err_ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compare every accepted result with the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [EW-1:0] exp_v;
            logic [EW-1:0] act_v;
            act_v = {sum_out, rem_out, err_div0, err_under, err_ovf};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got 0x%0h with empty queue", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL result: got sum=0x%0h rem=%0d d0=%0b un=%0b ov=%0b expected sum=0x%0h rem=%0d d0=%0b un=%0b ov=%0b",
                             act_v[EW-1 -: SW], act_v[AW+2:3], act_v[2], act_v[1], act_v[0],
                             exp_v[EW-1 -: SW], exp_v[AW+2:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // driver: wait (bounded) for in_ready; called at posedge+1
    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
    endtask

    // driver: wait (bounded) for out_valid and check edges since accept
    task automatic wait_valid(input int lat);
        int edges;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(lat));
    endtask

    // driver: one full operation with its expected response
    task automatic do_op(input logic [PW-1:0] p, input logic [PW-1:0] c, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input logic [AW-1:0] r,
                         input logic d0, input logic un, input logic ov, input int lat);
        wait_ready();
        in_valid = 1'b1;
        p_in = p;
        c_in = c;
        a_in = a;
        @(posedge clk);
        exp_q.push_back({s, r, d0, un, ov});
        #1 in_valid = 1'b0;
        wait_valid(lat);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p_in      = '0;
        c_in      = '0;
        a_in      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("reset_in_ready",  64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs",   64'({sum_out, rem_out, err_div0, err_under, err_ovf}), 64'd0);
        chk("reset_state",     64'(dbg_state), 64'd0);

        // main function
        do_op(48'd52,      48'd7,  18'd3,    19'd15,  18'd0,   1'b0, 1'b0, 1'b0, NORM_LAT);
        do_op(48'd123457,  48'd5,  18'd1000, 19'd123, 18'd452, 1'b0, 1'b0, 1'b0, NORM_LAT);
        do_op(48'd78643910, 48'd10, 18'd262143, 19'd300, 18'd1000, 1'b0, 1'b0, 1'b0, NORM_LAT);
        do_op(48'd77,      48'd77, 18'd5,    19'd0,   18'd0,   1'b0, 1'b0, 1'b0, NORM_LAT);

        // error paths
        do_op(48'd100, 48'd0, 18'd0, 19'd0, 18'd0, 1'b1, 1'b0, 1'b0, 1);
        do_op(48'd5,   48'd7, 18'd0, 19'd0, 18'd0, 1'b1, 1'b1, 1'b0, 1);
        do_op(48'd5,   48'd7, 18'd4, 19'd0, 18'd0, 1'b0, 1'b1, 1'b0, 1);

        // saturation boundary
        do_op(48'h100000, 48'd0, 18'd1, 19'h7FFFF, 18'd0, 1'b0, 1'b0, 1'b1, NORM_LAT);
        do_op(48'd524287, 48'd0, 18'd1, 19'h7FFFF, 18'd0, 1'b0, 1'b0, 1'b0, NORM_LAT);
        do_op(48'd524289, 48'd0, 18'd1, 19'h7FFFF, 18'd0, 1'b0, 1'b0, 1'b1, NORM_LAT);

        // back-pressure: hold the result for 5 cycles with in_valid asserted
        out_ready = 1'b0;
        do_op(48'd52, 48'd7, 18'd3, 19'd15, 18'd0, 1'b0, 1'b0, 1'b0, NORM_LAT);
        in_valid = 1'b1;
        p_in = 48'd123457;
        c_in = 48'd5;
        a_in = 18'd1000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready",  64'(in_ready), 64'd0);
            chk("stall_outputs",   64'({sum_out, rem_out, err_div0, err_under, err_ovf}),
                64'({19'd15, 18'd0, 3'b000}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handshake_out_valid", 64'(out_valid), 64'd0);
        chk("handshake_in_ready",  64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back({19'd123, 18'd452, 3'b000});
        #1;
        chk("next_accept", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_valid(NORM_LAT);
        @(posedge clk); #1;

        // reset mid-division at counter 20
        wait_ready();
        in_valid = 1'b1;
        p_in = 48'd52;
        c_in = 48'd7;
        a_in = 18'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_in_ready",  64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_outputs",   64'({sum_out, rem_out, err_div0, err_under, err_ovf}), 64'd0);
        exp_q.delete();
        do_op(48'd123457, 48'd5, 18'd1000, 19'd123, 18'd452, 1'b0, 1'b0, 1'b0, NORM_LAT);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
